// File: rtl/board_input_ctrl.sv
// board_input_ctrl: button conditioning and board-level reset generation.
//   - per-channel 2-flop synchronizer, polarity fix-up and debouncer
//   - press/release one-cycle pulses on debounced edges
//   - power-on reset stretch driving the registered sys_rst_n
//   - free-running heartbeat square wave
// Optional feature macro: LONG_HOLD_RESET_EN
//   defined   -> a long hold on HOLD_CHANNEL raises hold_active and pulls sys_rst_n low
//   undefined -> no hold counter, hold_active tied low, sys_rst_n follows POR only
module board_input_ctrl #(
   parameter int                 NUM_BTN          = 4,
   parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK  = '0,
   parameter int                 DEBOUNCE_CYCLES  = 50000,
   parameter int                 HOLD_CHANNEL     = 0,
   parameter int                 HOLD_CYCLES      = 25200000,
   parameter int                 POR_CYCLES       = 512,
   parameter int                 HEARTBEAT_CYCLES = 12600000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic               hold_active,
   output logic               sys_rst_n,
   output logic               heartbeat
);

   localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW  = (POR_CYCLES > 0) ? $clog2(POR_CYCLES + 1) : 1;
   localparam int HBW = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;

   // The level flips on the edge where the counter would reach DEBOUNCE_CYCLES,
   // so the compare is against the value just below it.
   localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0]  POR_MAX = PW'(POR_CYCLES);
   localparam logic [HBW-1:0] HB_LAST = HBW'(HEARTBEAT_CYCLES - 1);

   logic [NUM_BTN-1:0] sync1;
   logic [NUM_BTN-1:0] sync2;
   logic [NUM_BTN-1:0] sample;
   logic [DW-1:0]      db_cnt [NUM_BTN];
   logic [PW-1:0]      por_cnt;
   logic               por_busy;
   logic [HBW-1:0]     hb_cnt;

   // Synchronizers idle at the inactive raw level so reset never looks like a press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= ACTIVE_LOW_MASK;
         sync2 <= ACTIVE_LOW_MASK;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   assign sample = sync2 ^ ACTIVE_LOW_MASK;

   // Per-channel debounce counter, level register and edge pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_level   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         for (int unsigned i = 0; i < NUM_BTN; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         btn_press   <= '0;
         btn_release <= '0;
         for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (sample[i] == btn_level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i]      <= '0;
               btn_level[i]   <= sample[i];
               btn_press[i]   <= sample[i];
               btn_release[i] <= ~sample[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef LONG_HOLD_RESET_EN
   localparam int            HW       = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

   logic [HW-1:0] hold_cnt;

   // Saturating hold counter; any debounced release clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else if (!btn_level[HOLD_CHANNEL]) begin
         hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

   assign hold_active = (hold_cnt == HOLD_MAX);
`else
   logic unused_hold_cfg;

   assign unused_hold_cfg = ^{32'(HOLD_CHANNEL), 32'(HOLD_CYCLES)};
   assign hold_active     = 1'b0;
`endif

   // Power-on stretch counter, saturating once the stretch has elapsed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         por_cnt <= '0;
      end else if (por_busy) begin
         por_cnt <= por_cnt + 1'b1;
      end
   end

   assign por_busy = (por_cnt < POR_MAX);

   // Registered downstream reset; the hold reset never feeds back into this block
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sys_rst_n <= 1'b0;
      end else begin
         sys_rst_n <= !(por_busy | hold_active);
      end
   end

   // Heartbeat half-period counter, toggling the output on each wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hb_cnt    <= '0;
         heartbeat <= 1'b0;
      end else if (hb_cnt == HB_LAST) begin
         hb_cnt    <= '0;
         heartbeat <= ~heartbeat;
      end else begin
         hb_cnt <= hb_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_board_input_ctrl.sv
// Bench for board_input_ctrl with a small configuration (4 buttons, channel 0
// active-low, debounce 4, hold 20, POR 8, heartbeat 10). Directed scenario
// tasks plus a randomized run, all checked against a behavioural model.
module tb_board_input_ctrl;

   localparam int         DB   = 4;
   localparam int         HOLD = 20;
   localparam int         POR  = 8;
   localparam int         HB   = 10;
   localparam logic [3:0] IDLE = 4'b0001;
`ifdef LONG_HOLD_RESET_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn_raw = IDLE;
   logic [3:0] btn_level, btn_press, btn_release;
   logic       hold_active, sys_rst_n, heartbeat;

   int total = 0;
   int bad   = 0;

   board_input_ctrl #(
      .NUM_BTN         (4),
      .ACTIVE_LOW_MASK (4'b0001),
      .DEBOUNCE_CYCLES (DB),
      .HOLD_CHANNEL    (0),
      .HOLD_CYCLES     (HOLD),
      .POR_CYCLES      (POR),
      .HEARTBEAT_CYCLES(HB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .hold_active(hold_active),
      .sys_rst_n  (sys_rst_n),
      .heartbeat  (heartbeat)
   );

   always #5 clk = ~clk;

   // Behavioural model: raw values wait two edges in a queue, a channel's level
   // flips after DB consecutive differing samples, POR and heartbeat are derived
   // arithmetically from the number of edges since reset release.
   logic [3:0] m_level, m_press, m_release, m_smp, m_lvl_prev;
   logic       m_hold, m_hold_prev, m_sys, m_hb;
   int         m_run [4];
   int         m_hold_cnt;
   int         m_since;
   logic [3:0] m_pipe [$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_level = '0; m_press = '0; m_release = '0;
         m_hold = 1'b0; m_sys = 1'b0; m_hb = 1'b0;
         m_hold_cnt = 0; m_since = 0;
         for (int unsigned i = 0; i < 4; i++) m_run[i] = 0;
         m_pipe = '{IDLE, IDLE};
      end else begin
         m_lvl_prev  = m_level;
         m_hold_prev = m_hold;
         m_smp       = m_pipe.pop_front() ^ IDLE;
         m_pipe.push_back(btn_raw);
         m_since++;
         m_press = '0; m_release = '0;
         for (int unsigned i = 0; i < 4; i++) begin
            if (m_smp[i] != m_level[i]) begin
               m_run[i]++;
               if (m_run[i] == DB) begin
                  m_level[i]   = m_smp[i];
                  m_press[i]   = m_smp[i];
                  m_release[i] = !m_smp[i];
                  m_run[i]     = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         if (HOLD_EN && m_lvl_prev[0]) m_hold_cnt = (m_hold_cnt < HOLD) ? m_hold_cnt + 1 : HOLD;
         else m_hold_cnt = 0;
         m_hold = HOLD_EN && (m_hold_cnt == HOLD);
         m_sys  = (m_since > POR) && !m_hold_prev;
         m_hb   = ((m_since / HB) % 2) == 1;
      end
   end

   logic [14:0] dut_v, exp_v;
   assign dut_v = {btn_level, btn_press, btn_release, hold_active, sys_rst_n, heartbeat};
   assign exp_v = {m_level, m_press, m_release, m_hold, m_sys, m_hb};

   task automatic test_reset();
      rst_n = 1'b0; btn_raw = IDLE;
      repeat (3) @(negedge clk);
      total++;
      if (dut_v !== 15'd0) begin
         bad++; $display("FAIL reset_state got=%b want=%b", dut_v, 15'd0);
      end
      total++;
      if (dut_v !== exp_v) begin
         bad++; $display("FAIL reset_model got=%b want=%b", dut_v, exp_v);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_por();
      for (int unsigned k = 1; k <= 25; k++) begin
         @(negedge clk);
         total++;
         if (sys_rst_n !== (k >= POR + 1)) begin
            bad++; $display("FAIL por k=%0d got=%b want=%b", k, sys_rst_n, (k >= POR + 1));
         end
         total++;
         if (heartbeat !== ((k / HB) % 2 == 1)) begin
            bad++; $display("FAIL heartbeat k=%0d got=%b want=%b", k, heartbeat, ((k / HB) % 2 == 1));
         end
         total++;
         if (dut_v !== exp_v) begin
            bad++; $display("FAIL por_model k=%0d got=%b want=%b", k, dut_v, exp_v);
         end
      end
   endtask

   task automatic test_press();
      btn_raw[1] = 1'b1;
      for (int unsigned k = 1; k <= 10; k++) begin
         @(negedge clk);
         total++;
         if (btn_level[1] !== (k >= DB + 2) || btn_press[1] !== (k == DB + 2)) begin
            bad++; $display("FAIL press k=%0d got=lvl%b/prs%b want=lvl%b/prs%b", k,
                            btn_level[1], btn_press[1], (k >= DB + 2), (k == DB + 2));
         end
         total++;
         if ({btn_level[3:2], btn_level[0], btn_press[3:2], btn_press[0]} !== 6'd0) begin
            bad++; $display("FAIL press_other k=%0d got=%b want=%b", k,
                            {btn_level[3:2], btn_level[0], btn_press[3:2], btn_press[0]}, 6'd0);
         end
         total++;
         if (dut_v !== exp_v) begin
            bad++; $display("FAIL press_model k=%0d got=%b want=%b", k, dut_v, exp_v);
         end
      end
   endtask

   task automatic test_glitch();
      for (int unsigned k = 0; k < 30; k++) begin
         btn_raw[2] = ((k % 10) < 3);
         @(negedge clk);
         total++;
         if ({btn_level[2], btn_press[2], btn_release[2]} !== 3'b000) begin
            bad++; $display("FAIL glitch k=%0d got=%b want=%b", k,
                            {btn_level[2], btn_press[2], btn_release[2]}, 3'b000);
         end
         total++;
         if (dut_v !== exp_v) begin
            bad++; $display("FAIL glitch_model k=%0d got=%b want=%b", k, dut_v, exp_v);
         end
      end
      btn_raw[2] = 1'b0;
   endtask

   task automatic test_hold();
      logic exp_lvl, exp_hold, exp_sys;
      btn_raw[0] = 1'b0;
      for (int unsigned k = 1; k <= 45; k++) begin
         @(negedge clk);
         exp_lvl  = (k >= DB + 2) && (k <= 35);
         exp_hold = HOLD_EN && (k >= DB + 2 + HOLD) && (k <= 36);
         exp_sys  = !(HOLD_EN && (k >= DB + 3 + HOLD) && (k <= 37));
         total++;
         if ({btn_level[0], hold_active, sys_rst_n} !== {exp_lvl, exp_hold, exp_sys}) begin
            bad++; $display("FAIL hold k=%0d got=lvl%b/hold%b/sys%b want=lvl%b/hold%b/sys%b", k,
                            btn_level[0], hold_active, sys_rst_n, exp_lvl, exp_hold, exp_sys);
         end
         total++;
         if (dut_v !== exp_v) begin
            bad++; $display("FAIL hold_model k=%0d got=%b want=%b", k, dut_v, exp_v);
         end
         if (k == 30) btn_raw[0] = 1'b1;
      end
   endtask

   task automatic test_rst_mid();
      total++;
      if (btn_level[1] !== 1'b1) begin
         bad++; $display("FAIL rst_mid_pre got=%b want=%b", btn_level[1], 1'b1);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (dut_v !== 15'd0) begin
         bad++; $display("FAIL rst_mid_async got=%b want=%b", dut_v, 15'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int unsigned k = 1; k <= 12; k++) begin
         @(negedge clk);
         total++;
         if (sys_rst_n !== (k >= POR + 1)) begin
            bad++; $display("FAIL rst_mid_por k=%0d got=%b want=%b", k, sys_rst_n, (k >= POR + 1));
         end
         total++;
         if (dut_v !== exp_v) begin
            bad++; $display("FAIL rst_mid_model k=%0d got=%b want=%b", k, dut_v, exp_v);
         end
      end
   endtask

   task automatic test_random();
      int unsigned rem [4];
      for (int unsigned i = 0; i < 4; i++) rem[i] = 0;
      for (int unsigned k = 0; k < 800; k++) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (rem[i] == 0) begin
               btn_raw[i] = 1'($urandom_range(0, 1));
               rem[i]     = $urandom_range(1, (i == 0) ? 40 : 10);
            end
            rem[i]--;
         end
         @(negedge clk);
         total++;
         if (dut_v !== exp_v) begin
            bad++; $display("FAIL random k=%0d raw=%b got=%b want=%b", k, btn_raw, dut_v, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_por();
      test_press();
      test_glitch();
      test_hold();
      test_rst_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
